// File: rtl/pla_tt_scanner.sv
// Truth-table scanner: walks every minterm of a single-output function,
// packs the responses into words and streams them out with an onset count.
module pla_tt_scanner #(
    parameter int N_IN   = 12,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    output logic [WORD_W-1:0] tt_data,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic              tt_last,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     onset_count
);

    localparam int IW = $clog2(WORD_W);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WORD_W-2:0] pack;

    logic out_free;
    logic idx_last;
    logic sample;
    logic load;
    logic accept;

    // The last bit of a word may only be sampled when the output slot is free.
    always_comb begin
        out_free = !tt_valid || tt_ready;
        idx_last = (idx == IDX_LAST);
        sample   = (state == S_SCAN) && (!idx_last || out_free);
        load     = sample && idx_last;
        accept   = tt_valid && tt_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            x_out       <= '0;
            idx         <= '0;
            pack        <= '0;
            tt_data     <= '0;
            tt_valid    <= 1'b0;
            tt_last     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            onset_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    tt_valid <= 1'b0;
                    if (start) begin
                        state       <= S_SCAN;
                        busy        <= 1'b1;
                        onset_count <= '0;
                        x_out       <= '0;
                        idx         <= '0;
                    end
                end
                S_SCAN: begin
                    if (sample) begin
                        if (!idx_last) begin
                            pack[idx] <= y_in;
                        end
                        onset_count <= onset_count + (N_IN+1)'(y_in);
                        x_out       <= x_out + N_IN'(1);
                        idx         <= idx + IW'(1);
                    end
                    if (load) begin
                        tt_data  <= {y_in, pack};
                        tt_valid <= 1'b1;
                        tt_last  <= (x_out == '1);
                        if (x_out == '1) begin
                            state <= S_DRAIN;
                        end
                    end else if (accept) begin
                        tt_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        tt_valid <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_tt_scanner.sv
// Directed bench for pla_tt_scanner: full scans under several functions
// and consumer back-pressure patterns, reset abort and start filtering.
module tb_pla_tt_scanner;

    localparam int N_IN   = 12;
    localparam int WORD_W = 16;
    localparam int NW     = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tt_ready = 1'b0;
    logic              y_in;
    logic [N_IN-1:0]   x_out;
    logic [WORD_W-1:0] tt_data;
    logic              tt_valid;
    logic              tt_last;
    logic              busy;
    logic              done;
    logic [N_IN:0]     onset_count;

    int mode = 2;
    int total = 0;
    int bad = 0;

    logic [WORD_W-1:0] words[$];
    bit                lasts[$];
    int                done_cnt;
    int                done_cyc;
    int                fv_cyc;
    int                busy_bad;
    int                stall_data_bad;
    bit                timed_out;
    logic [N_IN-1:0]   x_stall;
    logic [WORD_W-1:0] w0;
    logic [N_IN:0]     onset_end;
    logic [N_IN-1:0]   ab_x;
    logic [WORD_W-1:0] ab_d;
    logic [3:0]        ab_flags;
    logic [N_IN:0]     ab_on;

    always #5 clk = ~clk;

    function automatic logic fn(int md, logic [N_IN-1:0] m);
        case (md)
            0: return m[0];
            1: return 1'b1;
            3: return m[4];
            4: return (m == 12'hABC);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] exp_word(int md, int w);
        logic [WORD_W-1:0] r;
        for (int k = 0; k < WORD_W; k++) begin
            r[k] = fn(md, N_IN'(w * WORD_W + k));
        end
        return r;
    endfunction

    always_comb y_in = fn(mode, x_out);

    pla_tt_scanner #(.N_IN(N_IN), .WORD_W(WORD_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x_out(x_out),
        .y_in(y_in),
        .tt_data(tt_data),
        .tt_valid(tt_valid),
        .tt_ready(tt_ready),
        .tt_last(tt_last),
        .busy(busy),
        .done(done),
        .onset_count(onset_count)
    );

    // rmode: 0 ready high, 1 stall 20 cycles at first word, 2 random
    task automatic do_scan(input int md, input int rmode, input bit spam,
                           input int abort_at);
        mode = md;
        words.delete();
        lasts.delete();
        done_cnt = 0;
        done_cyc = -1;
        fv_cyc = -1;
        busy_bad = 0;
        stall_data_bad = 0;
        x_stall = '0;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 20000; cyc++) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                ab_x = x_out;
                ab_d = tt_data;
                ab_on = onset_count;
                ab_flags = {tt_valid, tt_last, busy, done};
                @(negedge clk);
                rst_n = 1'b1;
                tt_ready = 1'b0;
                timed_out = 1'b0;
                return;
            end
            if (fv_cyc < 0 && tt_valid) begin
                fv_cyc = cyc;
                w0 = tt_data;
            end
            case (rmode)
                1: tt_ready = !(fv_cyc >= 0 && cyc < fv_cyc + 20);
                2: tt_ready = 1'($urandom_range(0, 1));
                default: tt_ready = 1'b1;
            endcase
            start = spam && done_cnt == 0 && (cyc % 7 == 3);
            #1;
            if (rmode == 1 && fv_cyc >= 0 && cyc < fv_cyc + 20 && tt_data !== w0)
                stall_data_bad++;
            if (rmode == 1 && cyc == fv_cyc + 19)
                x_stall = x_out;
            if (done_cnt == 0 && done !== 1'b1 && busy !== 1'b1)
                busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (tt_valid && tt_ready) begin
                words.push_back(tt_data);
                lasts.push_back(tt_last);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tt_ready = 1'b0;
        onset_end = onset_count;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (x_out !== '0) begin
            bad++; $display("FAIL reset_x got=%h want=0", x_out);
        end
        total++;
        if (tt_data !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", tt_data);
        end
        total++;
        if ({tt_valid, tt_last, busy, done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000",
                     {tt_valid, tt_last, busy, done});
        end
        total++;
        if (onset_count !== '0) begin
            bad++; $display("FAIL reset_onset got=%0d want=0", onset_count);
        end
    endtask

    task automatic test_alternating();
        do_scan(0, 0, 1'b0, 0);
        total++;
        if (timed_out) begin
            bad++; $display("FAIL alt_timeout got=timeout want=done");
        end
        total++;
        if (words.size() != NW) begin
            bad++; $display("FAIL alt_count got=%0d want=%0d", words.size(), NW);
        end
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== 16'hAAAA) begin
                bad++; $display("FAIL alt_word%0d got=%h want=aaaa", i, words[i]);
            end
            total++;
            if (lasts[i] !== (i == NW - 1)) begin
                bad++; $display("FAIL alt_last%0d got=%0d want=%0d",
                                i, lasts[i], i == NW - 1);
            end
        end
        total++;
        if (onset_end !== 13'd2048) begin
            bad++; $display("FAIL alt_onset got=%0d want=2048", onset_end);
        end
        total++;
        if (done_cnt != 1) begin
            bad++; $display("FAIL alt_done_cnt got=%0d want=1", done_cnt);
        end
        total++;
        if (done_cyc != 4098) begin
            bad++; $display("FAIL alt_done_cyc got=%0d want=4098", done_cyc);
        end
        total++;
        if (fv_cyc != 17) begin
            bad++; $display("FAIL alt_first_valid got=%0d want=17", fv_cyc);
        end
        total++;
        if (busy_bad != 0) begin
            bad++; $display("FAIL alt_busy got=%0d want=0", busy_bad);
        end
    endtask

    task automatic test_constant();
        do_scan(1, 0, 1'b0, 0);
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL ones_count got=%0d want=%0d", words.size(), NW);
        end
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== 16'hFFFF) begin
                bad++; $display("FAIL ones_word%0d got=%h want=ffff", i, words[i]);
            end
        end
        total++;
        if (onset_end !== 13'h1000) begin
            bad++; $display("FAIL ones_onset got=%h want=1000", onset_end);
        end
        do_scan(2, 0, 1'b0, 0);
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL zeros_count got=%0d want=%0d", words.size(), NW);
        end
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== 16'h0000) begin
                bad++; $display("FAIL zeros_word%0d got=%h want=0000", i, words[i]);
            end
        end
        total++;
        if (onset_end !== 13'd0) begin
            bad++; $display("FAIL zeros_onset got=%0d want=0", onset_end);
        end
    endtask

    task automatic test_stall();
        do_scan(3, 1, 1'b0, 0);
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL stall_count got=%0d want=%0d", words.size(), NW);
        end
        total++;
        if (w0 !== 16'h0000) begin
            bad++; $display("FAIL stall_w0 got=%h want=0000", w0);
        end
        total++;
        if (stall_data_bad != 0) begin
            bad++; $display("FAIL stall_hold got=%0d want=0", stall_data_bad);
        end
        total++;
        if (x_stall !== 12'd31) begin
            bad++; $display("FAIL stall_x got=%0d want=31", x_stall);
        end
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== exp_word(3, i)) begin
                bad++; $display("FAIL stall_word%0d got=%h want=%h",
                                i, words[i], exp_word(3, i));
            end
        end
        total++;
        if (onset_end !== 13'd2048) begin
            bad++; $display("FAIL stall_onset got=%0d want=2048", onset_end);
        end
    endtask

    task automatic test_single_minterm();
        int nz;
        do_scan(4, 2, 1'b0, 0);
        nz = 0;
        foreach (words[i]) if (words[i] != '0) nz++;
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL one_count got=%0d want=%0d", words.size(), NW);
        end
        total++;
        if (nz != 1) begin
            bad++; $display("FAIL one_nonzero got=%0d want=1", nz);
        end
        total++;
        if (words.size() > 171 && words[171] !== 16'h1000) begin
            bad++; $display("FAIL one_word171 got=%h want=1000", words[171]);
        end
        total++;
        if (onset_end !== 13'd1) begin
            bad++; $display("FAIL one_onset got=%0d want=1", onset_end);
        end
        total++;
        if (done_cnt != 1) begin
            bad++; $display("FAIL one_done_cnt got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_abort();
        do_scan(0, 0, 1'b0, 1000);
        total++;
        if (ab_x !== '0 || ab_d !== '0 || ab_on !== '0) begin
            bad++; $display("FAIL abort_regs got=x%h d%h on%0d want=0", ab_x, ab_d, ab_on);
        end
        total++;
        if (ab_flags !== 4'b0) begin
            bad++; $display("FAIL abort_flags got=%b want=0000", ab_flags);
        end
        do_scan(1, 0, 1'b0, 0);
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL rescan_count got=%0d want=%0d", words.size(), NW);
        end
        total++;
        if (onset_end !== 13'h1000) begin
            bad++; $display("FAIL rescan_onset got=%h want=1000", onset_end);
        end
        total++;
        if (done_cyc != 4098) begin
            bad++; $display("FAIL rescan_done_cyc got=%0d want=4098", done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        do_scan(0, 0, 1'b1, 0);
        total++;
        if (timed_out || words.size() != NW) begin
            bad++; $display("FAIL spam_count got=%0d want=%0d", words.size(), NW);
        end
        for (int i = 0; i < words.size(); i++) begin
            total++;
            if (words[i] !== exp_word(0, i)) begin
                bad++; $display("FAIL spam_word%0d got=%h want=%h",
                                i, words[i], exp_word(0, i));
            end
        end
        total++;
        if (done_cyc != 4098 || done_cnt != 1) begin
            bad++; $display("FAIL spam_done got=cyc%0d n%0d want=cyc4098 n1",
                            done_cyc, done_cnt);
        end
        total++;
        if (busy_bad != 0) begin
            bad++; $display("FAIL spam_busy got=%0d want=0", busy_bad);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tt_valid !== 1'b0) begin
            bad++; $display("FAIL spam_idle got=%b%b want=00", busy, tt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_constant();
        test_stall();
        test_single_minterm();
        test_abort();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
